// File: rtl/mpu_commit_tracker.sv
// mpu_commit_tracker
//   Sits after the MPU hazard-check stage. Issued scalar threads are queued,
//   dispatched to the lowest free TPU, tracked until that TPU reports the end,
//   then retired one per cycle with a commit pulse carrying the issue no. back
//   to the hazard table.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   I_Req_Issue           1-cycle issue pulse with I_ThreadID_S / I_IssueNo
//   O_Full                issue queue full (a request this cycle is dropped)
//   O_Dispatch_Req/TPU/ID registered dispatch pulse, one-hot TPU, thread-ID
//   I_TPU_End             per-TPU completion pulse
//   O_Req_Commit          registered commit pulse, O_Issued_No its issue no.
//   O_Err_Overflow        sticky: issue dropped while full
//   O_Err_Spurious        sticky: end pulse for a TPU that was not running

// Per-TPU slot: IDLE -> RUN on dispatch, RUN -> DONE on end,
// DONE -> IDLE when its commit is granted.
module mpu_commit_tracker_slot #(
  parameter int WIDTH_ID    = 8,
  parameter int WIDTH_ISSUE = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   dispatch,
  input  logic [WIDTH_ID-1:0]    id_in,
  input  logic [WIDTH_ISSUE-1:0] no_in,
  input  logic                   tpu_end,
  input  logic                   grant,
  output logic                   idle,
  output logic                   done,
  output logic                   spurious,
  output logic [WIDTH_ID-1:0]    id,
  output logic [WIDTH_ISSUE-1:0] no
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      id    <= '0;
      no    <= '0;
    end else begin
      state <= state_nxt;
      if (dispatch) begin
        id <= id_in;
        no <= no_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (dispatch) state_nxt = S_RUN;
      S_RUN:   if (tpu_end)  state_nxt = S_DONE;
      S_DONE:  if (grant)    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign idle     = (state == S_IDLE);
  assign done     = (state == S_DONE);
  // An end on a slot that is not running is ignored and only flagged.
  assign spurious = tpu_end & (state != S_RUN);
endmodule

module mpu_commit_tracker #(
  parameter int NUM_TPU     = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int WIDTH_ID    = 8,
  parameter int WIDTH_ISSUE = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_Req_Issue,
  input  logic [WIDTH_ID-1:0]    I_ThreadID_S,
  input  logic [WIDTH_ISSUE-1:0] I_IssueNo,
  output logic                   O_Full,
  output logic                   O_Dispatch_Req,
  output logic [NUM_TPU-1:0]     O_Dispatch_TPU,
  output logic [WIDTH_ID-1:0]    O_Dispatch_ID,
  input  logic [NUM_TPU-1:0]     I_TPU_End,
  output logic                   O_Req_Commit,
  output logic [WIDTH_ISSUE-1:0] O_Issued_No,
  output logic                   O_Err_Overflow,
  output logic                   O_Err_Spurious
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // ---------------- issue queue ----------------
  logic [FIFO_DEPTH-1:0][WIDTH_ID-1:0]    fifo_id;
  logic [FIFO_DEPTH-1:0][WIDTH_ISSUE-1:0] fifo_no;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  assign O_Full = (count == FULL_CNT);
  // Push is judged on the registered count, so a full queue refuses even
  // when it is popping in the same cycle.
  assign push   = I_Req_Issue & ~O_Full;

  // ---------------- slots ----------------
  logic [NUM_TPU-1:0]                  slot_idle, slot_done, slot_spur;
  logic [NUM_TPU-1:0]                  disp_oh, grant_oh, slot_disp;
  logic [NUM_TPU-1:0][WIDTH_ID-1:0]    slot_id;
  logic [NUM_TPU-1:0][WIDTH_ISSUE-1:0] slot_no;
  logic                                any_idle, any_done;
  logic [WIDTH_ISSUE-1:0]              commit_no;

  // Lowest-index IDLE slot takes the dispatch; lowest-index DONE slot commits.
  always_comb begin
    disp_oh   = '0;
    grant_oh  = '0;
    any_idle  = 1'b0;
    any_done  = 1'b0;
    commit_no = '0;
    for (int k = 0; k < NUM_TPU; k++) begin
      if (!any_idle && slot_idle[k]) begin
        disp_oh[k] = 1'b1;
        any_idle   = 1'b1;
      end
      if (!any_done && slot_done[k]) begin
        grant_oh[k] = 1'b1;
        any_done    = 1'b1;
        commit_no   = slot_no[k];
      end
    end
  end

  assign pop       = (count != '0) & any_idle;
  assign slot_disp = pop ? disp_oh : '0;

  for (genvar k = 0; k < NUM_TPU; k++) begin : g_slot
    mpu_commit_tracker_slot #(
      .WIDTH_ID    (WIDTH_ID),
      .WIDTH_ISSUE (WIDTH_ISSUE)
    ) u_slot (
      .clock    (clock),
      .reset    (reset),
      .dispatch (slot_disp[k]),
      .id_in    (fifo_id[rd_ptr]),
      .no_in    (fifo_no[rd_ptr]),
      .tpu_end  (I_TPU_End[k]),
      .grant    (grant_oh[k]),
      .idle     (slot_idle[k]),
      .done     (slot_done[k]),
      .spurious (slot_spur[k]),
      .id       (slot_id[k]),
      .no       (slot_no[k])
    );
  end

  // ---------------- sequential ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_id        <= '0;
      fifo_no        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      O_Dispatch_Req <= 1'b0;
      O_Dispatch_TPU <= '0;
      O_Dispatch_ID  <= '0;
      O_Req_Commit   <= 1'b0;
      O_Issued_No    <= '0;
      O_Err_Overflow <= 1'b0;
      O_Err_Spurious <= 1'b0;
    end else begin
      if (push) begin
        fifo_id[wr_ptr] <= I_ThreadID_S;
        fifo_no[wr_ptr] <= I_IssueNo;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);

      O_Dispatch_Req <= pop;
      O_Dispatch_TPU <= slot_disp;
      O_Dispatch_ID  <= pop ? fifo_id[rd_ptr] : '0;
      O_Req_Commit   <= any_done;
      O_Issued_No    <= commit_no;
      if (I_Req_Issue && O_Full) O_Err_Overflow <= 1'b1;
      if (|slot_spur)            O_Err_Spurious <= 1'b1;
    end
  end
endmodule
